// File: rtl/ir_nec_pkg.sv
// Shared definitions for the NEC infrared transmitter: FSM states, unit
// durations and the frame word layout.
package ir_nec_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_GAP,
        S_REP_MARK,
        S_REP_SPACE,
        S_REP_STOP
    } nec_state_t;

    localparam int LEAD_MARK_U  = 16;
    localparam int LEAD_SPACE_U = 8;
    localparam int REP_SPACE_U  = 4;
    localparam int ZERO_SPACE_U = 1;
    localparam int ONE_SPACE_U  = 3;
    localparam int BIT_MARK_U   = 1;

    // Frame word as sent LSB first: custom code, command, inverted command.
    function automatic logic [31:0] build_word(input logic [15:0] custom, input logic [7:0] cmd);
        return {~cmd, cmd, custom};
    endfunction

    function automatic logic is_mark(input nec_state_t s);
        return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK) ||
               (s == S_REP_MARK)  || (s == S_REP_STOP);
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// 38 kHz carrier generator; the phase restarts at every mark entry so each
// mark begins with a high carrier slice.
module ir_carrier_gen #(
    parameter int CARRIER_DIV  = 1316,
    parameter int CARRIER_HIGH = 439
) (
    input  logic iCLK,
    input  logic iRST_n,
    input  logic enable,
    input  logic restart,
    output logic carrier
);
    localparam int CW = $clog2(CARRIER_DIV + 1);

    logic [CW-1:0] phase_reg;
    logic [CW-1:0] phase_next;
    logic          carrier_reg;

    // enable/restart describe the upcoming cycle, so the output is registered
    // from the phase that cycle will have.
    always_comb begin
        phase_next = phase_reg + 1'b1;
        if (restart || (phase_reg == CW'(CARRIER_DIV - 1))) begin
            phase_next = '0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            phase_reg   <= '0;
            carrier_reg <= 1'b0;
        end else begin
            phase_reg   <= phase_next;
            carrier_reg <= enable && (phase_next < CW'(CARRIER_HIGH));
        end
    end

    assign carrier = carrier_reg;

endmodule

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: serialises {~cmd, cmd, custom} LSB first and sends
// repeat codes every frame period while iREPEAT is held.
module ir_nec_tx
    import ir_nec_pkg::*;
#(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_DIV  = 1316,
    parameter int CARRIER_HIGH = 439,
    parameter int FRAME_UNITS  = 192
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iVALID,
    output logic        oREADY,
    input  logic [15:0] iCUSTOM,
    input  logic [7:0]  iCMD,
    input  logic        iREPEAT,
    output logic        oIRDA_TX,
    output logic        oIRDA_ENV_n,
    output logic        oBUSY,
    output logic        oDONE
);
    localparam int UW = $clog2(UNIT_CYCLES + 1);
    localparam int FW = $clog2(FRAME_UNITS + 1);

    nec_state_t    state_reg, state_next;
    logic [UW-1:0] unit_reg, unit_next;
    logic [4:0]    span_reg, span_next;
    logic [4:0]    bit_reg, bit_next;
    logic [FW-1:0] frame_reg, frame_next;
    logic [31:0]   word_reg, word_next;
    logic          done_next;
    logic          ready_reg, busy_reg, env_reg, done_reg;
    logic [4:0]    span_len;
    logic          unit_tick;
    logic          span_last;

    always_comb begin
        span_len = 5'(BIT_MARK_U);
        case (state_reg)
            S_LEAD_MARK, S_REP_MARK: span_len = 5'(LEAD_MARK_U);
            S_LEAD_SPACE:            span_len = 5'(LEAD_SPACE_U);
            S_BIT_SPACE:             span_len = word_reg[bit_reg] ? 5'(ONE_SPACE_U) : 5'(ZERO_SPACE_U);
            S_REP_SPACE:             span_len = 5'(REP_SPACE_U);
            default:                 span_len = 5'(BIT_MARK_U);
        endcase
    end

    assign unit_tick = (unit_reg == UW'(UNIT_CYCLES - 1));
    assign span_last = (span_reg == span_len - 5'd1);

    always_comb begin
        state_next = state_reg;
        unit_next  = unit_reg;
        span_next  = span_reg;
        bit_next   = bit_reg;
        frame_next = frame_reg;
        word_next  = word_reg;
        done_next  = 1'b0;

        if (state_reg == S_IDLE) begin
            unit_next  = '0;
            span_next  = '0;
            bit_next   = '0;
            frame_next = '0;
            if (iVALID) begin
                state_next = S_LEAD_MARK;
                word_next  = build_word(iCUSTOM, iCMD);
            end
        end else begin
            unit_next = unit_tick ? '0 : unit_reg + 1'b1;
            if (unit_tick) begin
                frame_next = frame_reg + 1'b1;
                span_next  = span_last ? '0 : span_reg + 1'b1;
                if (state_reg == S_GAP) begin
                    // GAP has no own length: it pads the period out to FRAME_UNITS.
                    span_next = '0;
                    if (frame_reg == FW'(FRAME_UNITS - 1)) begin
                        frame_next = '0;
                        if (iREPEAT) begin
                            state_next = S_REP_MARK;
                        end else begin
                            state_next = S_IDLE;
                            done_next  = 1'b1;
                        end
                    end
                end else if (span_last) begin
                    case (state_reg)
                        S_LEAD_MARK:  state_next = S_LEAD_SPACE;
                        S_LEAD_SPACE: state_next = S_BIT_MARK;
                        S_BIT_MARK:   state_next = S_BIT_SPACE;
                        S_BIT_SPACE: begin
                            if (bit_reg == 5'd31) begin
                                state_next = S_STOP_MARK;
                            end else begin
                                state_next = S_BIT_MARK;
                                bit_next   = bit_reg + 5'd1;
                            end
                        end
                        S_STOP_MARK:  state_next = S_GAP;
                        S_REP_MARK:   state_next = S_REP_SPACE;
                        S_REP_SPACE:  state_next = S_REP_STOP;
                        S_REP_STOP:   state_next = S_GAP;
                        default:      state_next = S_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_reg <= S_IDLE;
            unit_reg  <= '0;
            span_reg  <= '0;
            bit_reg   <= '0;
            frame_reg <= '0;
            word_reg  <= '0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            env_reg   <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            unit_reg  <= unit_next;
            span_reg  <= span_next;
            bit_reg   <= bit_next;
            frame_reg <= frame_next;
            word_reg  <= word_next;
            ready_reg <= (state_next == S_IDLE);
            busy_reg  <= (state_next != S_IDLE);
            env_reg   <= !is_mark(state_next);
            done_reg  <= done_next;
        end
    end

    ir_carrier_gen #(
        .CARRIER_DIV (CARRIER_DIV),
        .CARRIER_HIGH(CARRIER_HIGH)
    ) u_carrier (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .enable (is_mark(state_next)),
        .restart(is_mark(state_next) && (state_next != state_reg)),
        .carrier(oIRDA_TX)
    );

    assign oREADY      = ready_reg;
    assign oBUSY       = busy_reg;
    assign oIRDA_ENV_n = env_reg;
    assign oDONE       = done_reg;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Scoreboard bench for ir_nec_tx: expected envelope runs are queued per request
// and compared against measured run lengths; carrier and handshake are checked too.
module tb_ir_nec_tx;
    localparam int UNIT    = 8;
    localparam int DIV     = 4;
    localparam int HIGH    = 1;
    localparam int FRAME_U = 192;
    localparam int PERIOD  = FRAME_U * UNIT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [15:0] custom = '0;
    logic [7:0]  cmd = '0;
    logic        rpt = 1'b0;
    logic        irda_tx;
    logic        env_n;
    logic        busy;
    logic        done;

    ir_nec_tx #(
        .UNIT_CYCLES (UNIT),
        .CARRIER_DIV (DIV),
        .CARRIER_HIGH(HIGH),
        .FRAME_UNITS (FRAME_U)
    ) dut (
        .iCLK       (clk),
        .iRST_n     (rst_n),
        .iVALID     (valid),
        .oREADY     (ready),
        .iCUSTOM    (custom),
        .iCMD       (cmd),
        .iREPEAT    (rpt),
        .oIRDA_TX   (irda_tx),
        .oIRDA_ENV_n(env_n),
        .oBUSY      (busy),
        .oDONE      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic lvl;
        int   len;
    } seg_t;
    seg_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_seg(input logic lvl, input int len);
        seg_t s;
        s.lvl = lvl;
        s.len = len;
        exp_q.push_back(s);
    endtask

    function automatic logic [31:0] nec_word(input logic [15:0] c, input logic [7:0] m);
        return {~m, m, c};
    endfunction

    function automatic int frame_active(input logic [31:0] w);
        int n = 24 * UNIT + UNIT;
        for (int i = 0; i < 32; i++) n += w[i] ? 4 * UNIT : 2 * UNIT;
        return n;
    endfunction

    task automatic push_frame(input logic [31:0] w);
        push_seg(1'b0, 16 * UNIT);
        push_seg(1'b1, 8 * UNIT);
        for (int i = 0; i < 32; i++) begin
            push_seg(1'b0, UNIT);
            push_seg(1'b1, w[i] ? 3 * UNIT : UNIT);
        end
        push_seg(1'b0, UNIT);
    endtask

    task automatic push_rep();
        push_seg(1'b0, 16 * UNIT);
        push_seg(1'b1, 4 * UNIT);
        push_seg(1'b0, UNIT);
    endtask

    // Envelope run-length monitor plus per-cycle carrier check.
    bit   mon_live = 1'b0;
    bit   mon_en = 1'b0;
    int   done_cnt = 0;
    initial begin
        logic prev_env;
        int   run_len;
        bit   run_idle;
        prev_env = 1'b1;
        run_len  = 0;
        run_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_live) begin
                if (done === 1'b1) done_cnt++;
                if (env_n === prev_env) begin
                    run_len++;
                    if (!busy) run_idle = 1'b1;
                end else begin
                    // Runs that touch IDLE have no defined length and are skipped.
                    if (mon_en && !run_idle && run_len > 0) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_run", run_len, 0);
                        end else begin
                            seg_t s;
                            s = exp_q.pop_front();
                            chk("env_level", prev_env, s.lvl);
                            chk("env_len", run_len, s.len);
                        end
                    end
                    prev_env = env_n;
                    run_len  = 1;
                    run_idle = !busy;
                end
                if (env_n === 1'b0) chk("tx_mark", irda_tx, ((run_len - 1) % DIV) < HIGH);
                else chk("tx_space", irda_tx, 0);
            end
        end
    end

    task automatic send(input logic [15:0] c, input logic [7:0] m, output int start);
        int t = 0;
        @(negedge clk);
        while (ready !== 1'b1 && t < 4 * PERIOD) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", ready, 1);
        custom = c;
        cmd    = m;
        valid  = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        start = cyc;
        chk("ready_fall", ready, 0);
        chk("busy_rise", busy, 1);
        chk("env_lead", env_n, 0);
        $display("request custom=%h cmd=%h accepted at cycle %0d", c, m, start);
    endtask

    task automatic wait_done(input int start, input int periods, input string tag);
        int t = 0;
        while (done !== 1'b1 && t < periods * PERIOD + 200) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done_at"}, cyc - start, periods * PERIOD);
        @(negedge clk);
        chk({tag, "_done_width"}, done, 0);
        chk({tag, "_ready_after"}, ready, 1);
        chk({tag, "_busy_after"}, busy, 0);
        $display("%s: done %0d cycles after lead entry", tag, cyc - 1 - start);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int dcnt;

        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tx", irda_tx, 0);
        chk("rst_env", env_n, 1);
        mon_live = 1'b1;
        mon_en   = 1'b1;

        // Basic frame 0xFD02FF00.
        push_frame(nec_word(16'hFF00, 8'h02));
        send(16'hFF00, 8'h02, st);
        wait_done(st, 1, "frame_ff00_02");

        // Different pattern.
        push_frame(nec_word(16'h1234, 8'hA5));
        send(16'h1234, 8'hA5, st);
        wait_done(st, 1, "frame_1234_a5");

        // Request while busy is dropped; frame still carries cmd 0x02.
        push_frame(nec_word(16'hFF00, 8'h02));
        send(16'hFF00, 8'h02, st);
        repeat (300) @(negedge clk);
        chk("busy_ready_low", ready, 0);
        custom = 16'hAAAA;
        cmd    = 8'h08;
        valid  = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        chk("ignored_ready_low", ready, 0);
        wait_done(st, 1, "ignored_valid");
        repeat (20) @(negedge clk);
        chk("no_queued_frame", busy, 0);

        // Held key: frame plus two repeat codes, one per period.
        rpt = 1'b1;
        push_frame(nec_word(16'hFF00, 8'h02));
        push_seg(1'b1, PERIOD - frame_active(nec_word(16'hFF00, 8'h02)));
        push_rep();
        push_seg(1'b1, PERIOD - 21 * UNIT);
        push_rep();
        send(16'hFF00, 8'h02, st);
        repeat (2 * PERIOD + 200) @(negedge clk);
        rpt = 1'b0;
        wait_done(st, 3, "repeat_x2");

        // Reset during bit 10 aborts the frame without a done pulse.
        mon_en = 1'b0;
        send(16'hFF00, 8'h02, st);
        repeat (386) @(negedge clk);
        chk("in_bit10_mark", env_n, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_env", env_n, 1);
        chk("abort_tx", irda_tx, 0);
        chk("abort_ready", ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        dcnt = done_cnt;
        repeat (PERIOD + 100) @(negedge clk);
        chk("abort_no_done", done_cnt - dcnt, 0);
        $display("reset abort during bit 10 handled");

        mon_en = 1'b1;
        push_frame(nec_word(16'hFF00, 8'h02));
        send(16'hFF00, 8'h02, st);
        wait_done(st, 1, "after_reset");
        repeat (10) @(negedge clk);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
